// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one registered bitwise-AND unit among N requesters.
// A three-state FSM (IDLE -> BUSY -> DONE) serves one requester per 3 cycles.
// Optional build macro LOGIC_ARB_FIXED_PRIO_EN: when defined, the lowest
// requesting index always wins and no rotation pointer exists; otherwise the
// winner is chosen round-robin starting from a pointer that advances past
// the last served requester.
module logic_unit_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  input  logic [N*W-1:0] b_bus,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   result,
  output logic           busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [W-1:0]       result_q, result_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [IDX_W-1:0]   win;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  function automatic logic [IDX_W-1:0] pick_fixed(input logic [N-1:0] r);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) w = IDX_W'(i);
    end
    return w;
  endfunction

  assign win = pick_fixed(req);
`else
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;

  // First requester at or above the pointer wins, wrapping past N-1 to 0.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0]     r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic             found;
    int               j;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(p) + i) % N;
      if (!found && r[IDX_W'(j)]) begin
        w     = IDX_W'(j);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = pick_rr(req, ptr_q);
`endif

  // Next-state and datapath-register update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
    sel_d    = sel_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|req) begin
          a_d          = a_bus[int'(win)*W +: W];
          b_d          = b_bus[int'(win)*W +: W];
          grant_d[win] = 1'b1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
          sel_d        = win;
`endif
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Operands are already latched, so bus or req changes here are ignored.
        result_d = a_q & b_q;
        ack_d    = grant_q;
        state_d  = DONE;
      end
      DONE: begin
        ack_d   = '0;
        grant_d = '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
        ptr_d   = (sel_q == IDX_W'(N - 1)) ? '0 : sel_q + 1'b1;
`endif
        state_d = IDLE;
      end
      default: begin
        ack_d   = '0;
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      ptr_q    <= '0;
      sel_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
`endif
    end
  end

  assign grant  = grant_q;
  assign ack    = ack_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed testbench for logic_unit_arbiter (N=4, W=8).
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           busy;

  int chk_cnt;
  int pass_cnt;

  logic_unit_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .grant  (grant),
    .ack    (ack),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; a_bus = '0; b_bus = '0;
    tick(); tick();
    rst = 1'b0;
    chk_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b expected %b", ack, 4'b0000); else pass_cnt++;
    chk_cnt++; if (result !== 8'h00) $display("FAIL reset_result: got %h expected %h", result, 8'h00); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
  endtask

  task automatic test_single();
    a_bus[0*W +: W] = 8'hF0;
    b_bus[0*W +: W] = 8'h3C;
    req = 4'b0001;
    tick(); // E1
    chk_cnt++; if (grant !== 4'b0001) $display("FAIL single_grant_e1: got %b expected %b", grant, 4'b0001); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0000) $display("FAIL single_ack_e1: got %b expected %b", ack, 4'b0000); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_e1: got %b expected %b", busy, 1'b1); else pass_cnt++;
    tick(); // E2
    chk_cnt++; if (grant !== 4'b0001) $display("FAIL single_grant_e2: got %b expected %b", grant, 4'b0001); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0001) $display("FAIL single_ack_e2: got %b expected %b", ack, 4'b0001); else pass_cnt++;
    chk_cnt++; if (result !== 8'h30) $display("FAIL single_result: got %h expected %h", result, 8'h30); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_e2: got %b expected %b", busy, 1'b1); else pass_cnt++;
    req = 4'b0000;
    tick(); // E3
    chk_cnt++; if (grant !== 4'b0000) $display("FAIL single_grant_e3: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0000) $display("FAIL single_ack_e3: got %b expected %b", ack, 4'b0000); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_e3: got %b expected %b", busy, 1'b0); else pass_cnt++;
    chk_cnt++; if (result !== 8'h30) $display("FAIL single_result_hold: got %h expected %h", result, 8'h30); else pass_cnt++;
  endtask

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  task automatic test_fairness();
    logic [3:0] exp_oh;
    int         order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    a_bus = {N*W{1'b1}};
    b_bus = {N*W{1'b1}};
    req = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      exp_oh = 4'b0001 << order[op];
      tick();
      chk_cnt++; if (grant !== exp_oh) $display("FAIL rr_grant_op%0d: got %b expected %b", op, grant, exp_oh); else pass_cnt++;
      chk_cnt++; if (ack !== 4'b0000) $display("FAIL rr_ack_early_op%0d: got %b expected %b", op, ack, 4'b0000); else pass_cnt++;
      tick();
      chk_cnt++; if (ack !== exp_oh) $display("FAIL rr_ack_op%0d: got %b expected %b", op, ack, exp_oh); else pass_cnt++;
      chk_cnt++; if (result !== 8'hFF) $display("FAIL rr_result_op%0d: got %h expected %h", op, result, 8'hFF); else pass_cnt++;
      tick();
      chk_cnt++; if (ack !== 4'b0000) $display("FAIL rr_ack_clear_op%0d: got %b expected %b", op, ack, 4'b0000); else pass_cnt++;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] exp_oh;
    int         order [3] = '{2, 3, 0};
    apply_reset();
    a_bus = {8'h11, 8'h22, 8'h44, 8'h88};
    b_bus = {N*W{1'b1}};
    for (int op = 0; op < 3; op++) begin
      req    = (op == 0) ? 4'b0100 : 4'b1001;
      exp_oh = 4'b0001 << order[op];
      tick();
      chk_cnt++; if (grant !== exp_oh) $display("FAIL wrap_grant_op%0d: got %b expected %b", op, grant, exp_oh); else pass_cnt++;
      tick();
      chk_cnt++; if (ack !== exp_oh) $display("FAIL wrap_ack_op%0d: got %b expected %b", op, ack, exp_oh); else pass_cnt++;
      tick();
    end
    // last served was requester 0 whose a operand is 8'h88
    chk_cnt++; if (result !== 8'h88) $display("FAIL wrap_result: got %h expected %h", result, 8'h88); else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask
`else
  task automatic test_fixed_prio();
    apply_reset();
    a_bus = {N*W{1'b1}};
    b_bus = {N*W{1'b1}};
    req = 4'b1010;
    for (int op = 0; op < 4; op++) begin
      tick();
      chk_cnt++; if (grant !== 4'b0010) $display("FAIL fixed_grant_op%0d: got %b expected %b", op, grant, 4'b0010); else pass_cnt++;
      tick();
      chk_cnt++; if (ack !== 4'b0010) $display("FAIL fixed_ack_op%0d: got %b expected %b", op, ack, 4'b0010); else pass_cnt++;
      tick();
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_operand_change();
    apply_reset();
    a_bus = '0; b_bus = '0;
    a_bus[0*W +: W] = 8'hAA;
    b_bus[0*W +: W] = 8'hFF;
    req = 4'b0001;
    tick(); // E1
    a_bus[0*W +: W] = 8'h00;
    tick(); // E2
    chk_cnt++; if (ack !== 4'b0001) $display("FAIL opchg_ack: got %b expected %b", ack, 4'b0001); else pass_cnt++;
    chk_cnt++; if (result !== 8'hAA) $display("FAIL opchg_result: got %h expected %h", result, 8'hAA); else pass_cnt++;
    req = 4'b0000;
    tick(); // E3
  endtask

  task automatic test_reset_mid();
    a_bus[2*W +: W] = 8'h5A;
    b_bus[2*W +: W] = 8'h0F;
    req = 4'b0100;
    tick(); // E1
    chk_cnt++; if (grant !== 4'b0100) $display("FAIL rstmid_grant_e1: got %b expected %b", grant, 4'b0100); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++; if (grant !== 4'b0000) $display("FAIL rstmid_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0000) $display("FAIL rstmid_ack: got %b expected %b", ack, 4'b0000); else pass_cnt++;
    chk_cnt++; if (result !== 8'h00) $display("FAIL rstmid_result: got %h expected %h", result, 8'h00); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    tick(); // restart E1
    chk_cnt++; if (grant !== 4'b0100) $display("FAIL rstmid_regrant: got %b expected %b", grant, 4'b0100); else pass_cnt++;
    chk_cnt++; if (ack !== 4'b0000) $display("FAIL rstmid_ack_early: got %b expected %b", ack, 4'b0000); else pass_cnt++;
    tick(); // restart E2
    chk_cnt++; if (ack !== 4'b0100) $display("FAIL rstmid_reack: got %b expected %b", ack, 4'b0100); else pass_cnt++;
    chk_cnt++; if (result !== 8'h0A) $display("FAIL rstmid_result2: got %h expected %h", result, 8'h0A); else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst   = 1'b1;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    test_reset();
    test_single();
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    test_fairness();
    test_wrap();
`else
    test_fixed_prio();
`endif
    test_operand_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
